// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI target endpoint with a one-word transmit holding register.
// Pins are synchronised to clk; all frame and bit timing is driven by detected pin edges.
module spi_slave #(
    parameter int              DW            = 8,
    parameter bit              CPOL          = 1'b1,
    parameter bit              CPHA          = 1'b1,
    parameter logic [DW-1:0]   UNDERRUN_WORD = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl,
    input  logic          ss,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic [7:0]    status
);

    localparam bit             SAMPLE_RISE = (CPOL == CPHA);
    localparam int             CW          = $clog2(DW + 1);
    localparam logic [CW-1:0]  CNT_FULL    = CW'(DW);
    localparam logic [CW-1:0]  CNT_LAST    = CW'(DW - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state;
    state_t        state_nxt;

    logic          scl_p0, scl_p1, scl_p2;
    logic          ss_p0, ss_p1, ss_p2;
    logic          mosi_p0, mosi_p1;

    logic          scl_rise, scl_fall;
    logic          sample_edge, shift_edge;
    logic          ss_fall, ss_rise;

    logic          frame_open, frame_close;
    logic          do_sample, do_shift;
    logic          busy;

    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic [DW-2:0] rx_shift;
    logic [DW-1:0] rx_word;
    logic [DW-1:0] tx_shift, tx_shift_nxt;
    logic [DW-1:0] hold_data;
    logic          hold_full;
    logic          tx_wr, tx_load, word_done;
    logic          tx_underrun, frame_err;

    // Stage p0/p1: two-flop synchronisers; p2: history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_p0  <= CPOL;
            scl_p1  <= CPOL;
            scl_p2  <= CPOL;
            ss_p0   <= 1'b1;
            ss_p1   <= 1'b1;
            ss_p2   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            scl_p0  <= scl;
            scl_p1  <= scl_p0;
            scl_p2  <= scl_p1;
            ss_p0   <= ss;
            ss_p1   <= ss_p0;
            ss_p2   <= ss_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign scl_rise    = scl_p1 & ~scl_p2;
    assign scl_fall    = ~scl_p1 & scl_p2;
    assign sample_edge = SAMPLE_RISE ? scl_rise : scl_fall;
    assign shift_edge  = SAMPLE_RISE ? scl_fall : scl_rise;
    assign ss_fall     = ~ss_p1 & ss_p2;
    assign ss_rise     = ss_p1 & ~ss_p2;

    // Frame FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame FSM: outputs; scl edges outside a frame are ignored
    always_comb begin
        frame_open  = 1'b0;
        frame_close = 1'b0;
        do_sample   = 1'b0;
        do_shift    = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                frame_open = ss_fall;
            end
            ACTIVE: begin
                busy        = 1'b1;
                do_sample   = sample_edge;
                do_shift    = shift_edge;
                frame_close = ss_rise;
            end
            default: ;
        endcase
    end

    assign tx_wr     = tx_valid & ~hold_full;
    assign tx_load   = frame_open | (do_shift & (bit_cnt == CNT_FULL));
    assign rx_word   = {rx_shift, mosi_p1};
    assign word_done = do_sample & (bit_cnt == CNT_LAST);

    always_comb begin
        bit_cnt_nxt  = bit_cnt;
        tx_shift_nxt = tx_shift;
        if (frame_open) begin
            bit_cnt_nxt = '0;
        end else if (do_sample && bit_cnt != CNT_FULL) begin
            bit_cnt_nxt = bit_cnt + 1'b1;
        end else if (do_shift && bit_cnt == CNT_FULL) begin
            bit_cnt_nxt = '0;
        end
        // Shift at count 0 is the CPHA=1 leading edge: the MSB is already on miso
        if (tx_load) begin
            tx_shift_nxt = hold_full ? hold_data : UNDERRUN_WORD;
        end else if (do_shift && bit_cnt != '0) begin
            tx_shift_nxt = {tx_shift[DW-2:0], 1'b0};
        end
    end

    // Stage: shift registers, holding register, flags and pin outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
        end else begin
            bit_cnt  <= bit_cnt_nxt;
            tx_shift <= tx_shift_nxt;
            rx_valid <= word_done;
            if (do_sample) begin
                rx_shift <= rx_word[DW-2:0];
            end
            if (word_done) begin
                rx_data <= rx_word;
            end

            // A same-cycle write lands after the load has taken the old contents
            if (tx_wr) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end else if (tx_load) begin
                hold_full <= 1'b0;
            end

            if (frame_open) begin
                tx_underrun <= ~hold_full;
            end else if (tx_load && !hold_full) begin
                tx_underrun <= 1'b1;
            end

            if (frame_open) begin
                frame_err <= 1'b0;
            end else if (frame_close && bit_cnt_nxt != '0 && bit_cnt_nxt != CNT_FULL) begin
                frame_err <= 1'b1;
            end

            if (state_nxt == ACTIVE) begin
                miso_oe <= 1'b1;
                miso    <= tx_shift_nxt[DW-1];
            end else begin
                miso_oe <= 1'b0;
                miso    <= 1'b0;
            end
        end
    end

    assign tx_ready = ~hold_full;
    assign status   = {busy, tx_underrun, frame_err, 5'h00};

endmodule
